// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter state
// encodings, the RISC-V B-type opcode and default table geometry.
package branch_predictor_pkg;

   // Two-bit saturating counter states; bit 1 is the taken/not-taken prediction.
   typedef enum logic [1:0] {
      CNT_SN = 2'b00,   // strongly not-taken
      CNT_WN = 2'b01,   // weakly not-taken
      CNT_WT = 2'b10,   // weakly taken
      CNT_ST = 2'b11    // strongly taken
   } cnt_e;

   // Opcode of conditional branches (B-type).
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Default table geometry: 16 entries, 8-bit partial tags.
   localparam int DEF_IDX_BITS = 4;
   localparam int DEF_TAG_BITS = 8;

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational next-state function of a 2-bit saturating counter.
// Ports:
//   cnt_i   - current counter state (SN/WN/WT/ST)
//   taken_i - resolved outcome: 1 steps toward ST, 0 steps toward SN
//   cnt_o   - next counter state, saturating at both ends
module bp_sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (taken_i) begin
         if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != CNT_SN) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch-stage lookup is combinational; MEM-stage resolution updates the
// table on the next clock edge and raises a redirect on a mispredict.
// Ports:
//   clk, rstn                    - clock, async active-low reset
//   if_pc                        - fetch PC to predict
//   pred_taken, pred_target      - prediction (target is 0 when not taken)
//   upd_valid, upd_is_branch     - MEM-stage instruction is a valid branch
//   upd_pc, upd_taken, upd_target- resolved branch information
//   upd_pred_taken/_target       - prediction carried with the instruction
//   redirect, redirect_pc        - mispredict flush and corrected fetch PC
//   perf_branches/_mispredicts   - wrapping event counters
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_BITS = DEF_IDX_BITS,
   parameter int TAG_BITS = DEF_TAG_BITS
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] if_pc,
   output logic        pred_taken,
   output logic [63:0] pred_target,
   input  logic        upd_valid,
   input  logic        upd_is_branch,
   input  logic [63:0] upd_pc,
   input  logic        upd_taken,
   input  logic [63:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [63:0] upd_pred_target,
   output logic        redirect,
   output logic [63:0] redirect_pc,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_LO  = 2 + IDX_BITS;

   logic                valid_q  [ENTRIES];
   cnt_e                cnt_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [63:0]         target_q [ENTRIES];
   logic [31:0]         branches_q, mispred_q;

   // Fetch-side lookup
   logic [IDX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0] if_tag;
   logic                if_hit;

   assign if_idx = if_pc[IDX_BITS+1:2];
   assign if_tag = if_pc[TAG_LO +: TAG_BITS];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   // Outputs are forced low while reset is held, independent of table state.
   assign pred_taken  = rstn && if_hit && cnt_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : 64'd0;

   // Update-side lookup
   logic [IDX_BITS-1:0] upd_idx;
   logic [TAG_BITS-1:0] upd_tag;
   logic                upd_en, upd_hit, mispredict;
   logic [1:0]          cnt_d;

   assign upd_idx = upd_pc[IDX_BITS+1:2];
   assign upd_tag = upd_pc[TAG_LO +: TAG_BITS];
   assign upd_en  = upd_valid && upd_is_branch;
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target)));

   assign redirect    = rstn && mispredict;
   assign redirect_pc = !redirect ? 64'd0 :
                        upd_taken ? upd_target : (upd_pc + 64'd4);

   bp_sat_counter2 u_cnt (
      .cnt_i   (cnt_q[upd_idx]),
      .taken_i (upd_taken),
      .cnt_o   (cnt_d)
   );

   // Valid bits, counters and perf counters need a defined reset state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_WN;
         end
         branches_q <= 32'd0;
         mispred_q  <= 32'd0;
      end else begin
         if (upd_en) begin
            branches_q <= branches_q + 32'd1;
            if (upd_hit) begin
               cnt_q[upd_idx] <= cnt_e'(cnt_d);
            end else if (upd_taken) begin
               valid_q[upd_idx] <= 1'b1;
               cnt_q[upd_idx]   <= CNT_WT;
            end
         end
         if (mispredict) mispred_q <= mispred_q + 32'd1;
      end
   end

   // Tag and target are only meaningful under a set valid bit, so they carry
   // no reset and a stray write during reset is harmless.
   always_ff @(posedge clk) begin
      if (upd_en && (upd_hit || upd_taken)) begin
         if (upd_taken) target_q[upd_idx] <= upd_target;
         if (!upd_hit)  tag_q[upd_idx]    <= upd_tag;
      end
   end

   assign perf_branches    = branches_q;
   assign perf_mispredicts = mispred_q;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[63:TAG_LO+TAG_BITS], if_pc[1:0]};

endmodule
